// File: rtl/tile_buffer_quad_unaligned.sv
// Four-bank 2x2-quad tile buffer with unaligned quad access, edge clipping,
// a read pipeline of RD_LAT cycles and a full-tile clear that stalls requests.
module tile_buffer_quad_unaligned #(
  parameter int POS_ADDRW   = 8,
  parameter int TILE_WIDTH  = 128,
  parameter int TILE_HEIGHT = 128,
  parameter int PIXEL_W     = 72,
  parameter int DEPTH_W     = 24,
  parameter int RD_LAT      = 1,
  parameter int BANK_SIZE   = (TILE_WIDTH/2)*(TILE_HEIGHT/2),
  parameter logic [PIXEL_W-1:0] INIT_CLEAR_VALUE = {{(PIXEL_W-DEPTH_W){1'b0}}, {DEPTH_W{1'b1}}}
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 o_ready,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [POS_ADDRW-1:0] i_wr_x,
  input  logic [POS_ADDRW-1:0] i_wr_y,
  input  logic [PIXEL_W-1:0]   i_wr_data [4],
  input  logic [3:0]           i_wr_mask,
  input  logic                 i_rd_valid,
  output logic                 o_rd_ready,
  input  logic [POS_ADDRW-1:0] i_rd_x,
  input  logic [POS_ADDRW-1:0] i_rd_y,
  output logic [PIXEL_W-1:0]   o_rd_data [4],
  output logic [3:0]           o_rd_inb,
  output logic                 o_rd_valid,
  input  logic                 i_clear,
  input  logic [PIXEL_W-1:0]   i_clear_value,
  output logic                 o_clear_done,
  output logic                 o_dbg_clearing
);
  localparam int BANK_AW = $clog2(BANK_SIZE);
  localparam int PW      = POS_ADDRW + 1;
  localparam logic [PW-1:0] TW_P = PW'(TILE_WIDTH);
  localparam logic [PW-1:0] TH_P = PW'(TILE_HEIGHT);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_clear_done;
  logic [PIXEL_W-1:0]   r_clear_val;
  logic [BANK_AW-1:0]   r_clear_addr;

  logic                 w_wr_fire;
  logic                 w_rd_fire;
  logic                 w_we    [4];
  logic [BANK_AW-1:0]   w_waddr [4];
  logic [PIXEL_W-1:0]   w_wdata [4];
  logic [BANK_AW-1:0]   w_raddr [4];
  logic [3:0]           w_rd_inb;
  logic [PIXEL_W-1:0]   w_bank_q [4];
  logic [PIXEL_W-1:0]   w_rd_data [4];

  logic [1:0]           r_rd_sel;
  logic [3:0]           r_rd_inb;
  logic                 r_v1;

  // Handshake: a request transfers on the clk edge where valid and ready are
  // both high; while ready is low the requester holds valid and its payload.
  assign o_ready        = r_ready;
  assign o_wr_ready     = r_ready;
  assign o_rd_ready     = r_ready;
  assign o_clear_done   = r_clear_done;
  assign o_dbg_clearing = (r_state == ST_CLEAR);
  assign w_wr_fire      = rstn && i_wr_valid && r_ready;
  assign w_rd_fire      = rstn && i_rd_valid && r_ready;

  // Coordinates are widened by one bit so x+1 / y+1 past the edge never wraps.
  function automatic void f_quad(input logic [POS_ADDRW-1:0] x, input logic [POS_ADDRW-1:0] y,
                                 input logic [1:0] q, output logic [BANK_AW-1:0] addr,
                                 output logic inb);
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    px   = {1'b0, x} + PW'(q[0]);
    py   = {1'b0, y} + PW'(q[1]);
    inb  = (px < TW_P) && (py < TH_P);
    addr = BANK_AW'(py >> 1) * BANK_AW'(TILE_WIDTH/2) + BANK_AW'(px >> 1);
  endfunction

  // Bank b serves quad pixel b ^ {y[0],x[0]}; the same xor un-swizzles reads.
  always_comb begin
    logic [1:0]         q;
    logic [BANK_AW-1:0] a;
    logic               inb;
    q = '0;
    a = '0;
    inb = 1'b0;
    for (int b = 0; b < 4; b++) begin
      q = 2'(b) ^ {i_wr_y[0], i_wr_x[0]};
      f_quad(i_wr_x, i_wr_y, q, a, inb);
      if (r_state == ST_CLEAR) begin
        w_we[b]    = rstn;
        w_waddr[b] = r_clear_addr;
        w_wdata[b] = r_clear_val;
      end else begin
        w_we[b]    = w_wr_fire && i_wr_mask[q] && inb;
        w_waddr[b] = a;
        w_wdata[b] = i_wr_data[q];
      end
      q = 2'(b) ^ {i_rd_y[0], i_rd_x[0]};
      f_quad(i_rd_x, i_rd_y, q, a, inb);
      w_raddr[b] = a;
    end
    for (int p = 0; p < 4; p++) begin
      f_quad(i_rd_x, i_rd_y, 2'(p), a, inb);
      w_rd_inb[p] = inb;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [PIXEL_W-1:0] r_mem [BANK_SIZE];
    logic [PIXEL_W-1:0] r_q;
    always_ff @(posedge clk) begin
      if (w_we[g]) r_mem[w_waddr[g]] <= w_wdata[g];
    end
    always_ff @(posedge clk) begin
      if (!rstn)          r_q <= '0;
      else if (w_rd_fire) r_q <= r_mem[w_raddr[g]];
    end
    assign w_bank_q[g] = r_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_sel <= '0;
      r_rd_inb <= '0;
      r_v1     <= 1'b0;
    end else begin
      r_v1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_sel <= {i_rd_y[0], i_rd_x[0]};
        r_rd_inb <= w_rd_inb;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++)
      w_rd_data[p] = r_rd_inb[p] ? w_bank_q[2'(p) ^ r_rd_sel] : '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [PIXEL_W-1:0] r_out_data [4];
    logic [3:0]         r_out_inb;
    logic               r_out_valid;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_out_data  <= '{default: '0};
        r_out_inb   <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_v1;
        if (r_v1) begin
          r_out_data <= w_rd_data;
          r_out_inb  <= r_rd_inb;
        end
      end
    end
    assign o_rd_data  = r_out_data;
    assign o_rd_inb   = r_out_inb;
    assign o_rd_valid = r_out_valid;
  end else begin : g_lat1
    assign o_rd_data  = w_rd_data;
    assign o_rd_inb   = r_rd_inb;
    assign o_rd_valid = r_v1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_CLEAR;
      r_clear_val  <= INIT_CLEAR_VALUE;
      r_clear_addr <= '0;
      r_ready      <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_state      <= ST_CLEAR;
            r_clear_val  <= i_clear_value;
            r_clear_addr <= '0;
            r_ready      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clear_addr == BANK_AW'(BANK_SIZE-1)) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_clear_done <= 1'b1;
          end else begin
            r_clear_addr <= r_clear_addr + BANK_AW'(1);
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_buffer_quad_unaligned.sv
// Directed bench for tile_buffer_quad_unaligned: one RD_LAT=1 and one RD_LAT=2
// instance share every input so latency differences are checked side by side.
module tb_tile_buffer_quad_unaligned;
  localparam int PW = 72;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          i_wr_valid, i_rd_valid, i_clear;
  logic [7:0]    i_wr_x, i_wr_y, i_rd_x, i_rd_y;
  logic [PW-1:0] wr_data [4];
  logic [3:0]    i_wr_mask;
  logic [PW-1:0] i_clear_value;

  logic          rdy1, wrr1, rdr1, v1, done1, dbg1;
  logic          rdy2, wrr2, rdr2, v2, done2, dbg2;
  logic [PW-1:0] d1 [4];
  logic [PW-1:0] d2 [4];
  logic [3:0]    inb1, inb2;

  int n_checks = 0;
  int n_err    = 0;

  tile_buffer_quad_unaligned #(.RD_LAT(1)) u1 (
    .clk(clk), .rstn(rstn), .o_ready(rdy1), .i_wr_valid(i_wr_valid), .o_wr_ready(wrr1),
    .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_data(wr_data), .i_wr_mask(i_wr_mask),
    .i_rd_valid(i_rd_valid), .o_rd_ready(rdr1), .i_rd_x(i_rd_x), .i_rd_y(i_rd_y),
    .o_rd_data(d1), .o_rd_inb(inb1), .o_rd_valid(v1), .i_clear(i_clear),
    .i_clear_value(i_clear_value), .o_clear_done(done1), .o_dbg_clearing(dbg1));

  tile_buffer_quad_unaligned #(.RD_LAT(2)) u2 (
    .clk(clk), .rstn(rstn), .o_ready(rdy2), .i_wr_valid(i_wr_valid), .o_wr_ready(wrr2),
    .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_data(wr_data), .i_wr_mask(i_wr_mask),
    .i_rd_valid(i_rd_valid), .o_rd_ready(rdr2), .i_rd_x(i_rd_x), .i_rd_y(i_rd_y),
    .o_rd_data(d2), .o_rd_inb(inb2), .o_rd_valid(v2), .i_clear(i_clear),
    .i_clear_value(i_clear_value), .o_clear_done(done2), .o_dbg_clearing(dbg2));

  function automatic logic [PW-1:0] mk(input logic [7:0] n);
    return {n, 40'h0, {3{n}}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [7:0] x, input logic [7:0] y, input logic [PW-1:0] e0,
                    input logic [PW-1:0] e1, input logic [PW-1:0] e2, input logic [PW-1:0] e3,
                    input logic [3:0] mask);
    @(negedge clk);
    i_wr_valid = 1'b1; i_wr_x = x; i_wr_y = y; i_wr_mask = mask;
    wr_data[0] = e0; wr_data[1] = e1; wr_data[2] = e2; wr_data[3] = e3;
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
  endtask

  // Reads one quad; checks RD_LAT=1 output after one cycle, then hold on u1
  // and the RD_LAT=2 output a cycle later.
  task automatic rd(input string tag, input logic [7:0] x, input logic [7:0] y,
                    input logic [PW-1:0] e0, input logic [PW-1:0] e1, input logic [PW-1:0] e2,
                    input logic [PW-1:0] e3, input logic [3:0] einb);
    logic [PW-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    @(negedge clk);
    i_rd_valid = 1'b1; i_rd_x = x; i_rd_y = y;
    @(posedge clk); #1;
    i_rd_valid = 1'b0;
    chk($sformatf("%s/l1_valid", tag), 128'(v1), 128'(1));
    chk($sformatf("%s/l2_not_yet", tag), 128'(v2), 128'(0));
    for (int q = 0; q < 4; q++) chk($sformatf("%s/l1_d%0d", tag, q), 128'(d1[q]), 128'(e[q]));
    chk($sformatf("%s/l1_inb", tag), 128'(inb1), 128'(einb));
    @(posedge clk); #1;
    chk($sformatf("%s/l1_drop", tag), 128'(v1), 128'(0));
    chk($sformatf("%s/l1_hold", tag), 128'(d1[3]), 128'(e[3]));
    chk($sformatf("%s/l2_valid", tag), 128'(v2), 128'(1));
    for (int q = 0; q < 4; q++) chk($sformatf("%s/l2_d%0d", tag, q), 128'(d2[q]), 128'(e[q]));
    chk($sformatf("%s/l2_inb", tag), 128'(inb2), 128'(einb));
  endtask

  initial begin
    logic [PW-1:0] ini, z0, a, b, c, d, e, f, g, h, k1, k3, x0, x1, x2, x3, v, y0, zz;
    int cnt;
    int bad;
    ini = {48'h0, 24'hFFFFFF};
    z0 = '0;
    a = mk(8'hA1); b = mk(8'hB2); c = mk(8'hC3); d = mk(8'hD4);
    e = mk(8'hE5); f = mk(8'hF6); g = mk(8'h17); h = mk(8'h28);
    k1 = mk(8'h39); k3 = mk(8'h4A);
    x0 = mk(8'h51); x1 = mk(8'h62); x2 = mk(8'h73); x3 = mk(8'h84);
    v = mk(8'h5C); y0 = mk(8'h95); zz = mk(8'hA6);
    i_wr_valid = 0; i_rd_valid = 0; i_clear = 0; i_wr_mask = '0;
    i_wr_x = '0; i_wr_y = '0; i_rd_x = '0; i_rd_y = '0; i_clear_value = '0;
    for (int q = 0; q < 4; q++) wr_data[q] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", 128'(rdy1), 128'(0));
    chk("rst/valid1", 128'(v1), 128'(0));
    chk("rst/valid2", 128'(v2), 128'(0));
    chk("rst/done", 128'(done1), 128'(0));
    chk("rst/data1", 128'(d1[0]), 128'(0));
    chk("rst/data2", 128'(d2[2]), 128'(0));
    chk("rst/inb", 128'(inb1), 128'(0));
    chk("rst/dbg", 128'(dbg1), 128'(1));

    // post-reset clear: done pulse on cycle BANK_SIZE after release
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    while (cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
      if (done1) break;
    end
    chk("init_clear/cycles", 128'(cnt), 128'(4096));
    chk("init_clear/ready", 128'(rdy1), 128'(1));
    chk("init_clear/wr_ready", 128'(wrr1), 128'(1));
    chk("init_clear/done2", 128'(done2), 128'(1));
    chk("init_clear/dbg", 128'(dbg1), 128'(0));
    @(posedge clk); #1;
    chk("init_clear/pulse", 128'(done1), 128'(0));
    rd("init_rd", 8'd0, 8'd0, ini, ini, ini, ini, 4'hF);

    // odd origin write/read and overlapping aligned read
    wr(8'd3, 8'd5, a, b, c, d, 4'hF);
    rd("odd_rd", 8'd3, 8'd5, a, b, c, d, 4'hF);
    rd("even_rd", 8'd2, 8'd4, ini, ini, ini, a, 4'hF);

    // right-edge clipping, no wrap to x=0 or next row
    wr(8'd127, 8'd10, e, f, g, h, 4'hF);
    rd("edge_rd", 8'd127, 8'd10, e, z0, g, z0, 4'b0101);
    rd("edge_x0", 8'd0, 8'd10, ini, ini, ini, ini, 4'hF);
    rd("edge_alias", 8'd0, 8'd12, ini, ini, ini, ini, 4'hF);
    wr(8'd127, 8'd127, x0, x1, x2, x3, 4'hF);
    rd("corner_rd", 8'd127, 8'd127, x0, z0, z0, z0, 4'b0001);
    rd("corner_alias", 8'd126, 8'd0, ini, ini, ini, ini, 4'hF);
    rd("far_oob", 8'd200, 8'd250, z0, z0, z0, z0, 4'b0000);

    // partial mask
    wr(8'd3, 8'd5, mk(8'hEE), k1, mk(8'hEF), k3, 4'b1010);
    rd("mask_rd", 8'd3, 8'd5, a, k1, c, k3, 4'hF);

    // same-cycle write and read to the same quad: read-first
    @(negedge clk);
    i_wr_valid = 1'b1; i_wr_x = 8'd4; i_wr_y = 8'd4; i_wr_mask = 4'hF;
    wr_data[0] = x0; wr_data[1] = x1; wr_data[2] = x2; wr_data[3] = x3;
    i_rd_valid = 1'b1; i_rd_x = 8'd4; i_rd_y = 8'd4;
    @(posedge clk); #1;
    i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    chk("rfirst/l1_d0", 128'(d1[0]), 128'(ini));
    chk("rfirst/l1_d2", 128'(d1[2]), 128'(k1));
    @(posedge clk); #1;
    chk("rfirst/l2_d2", 128'(d2[2]), 128'(k1));
    rd("rfirst_after", 8'd4, 8'd4, x0, x1, x2, x3, 4'hF);

    // clear while streaming: requests in the clear cycle go first, later ones stall
    @(negedge clk);
    i_clear = 1'b1; i_clear_value = v;
    i_wr_valid = 1'b1; i_wr_x = 8'd10; i_wr_y = 8'd10; i_wr_mask = 4'hF;
    for (int q = 0; q < 4; q++) wr_data[q] = y0;
    i_rd_valid = 1'b1; i_rd_x = 8'd3; i_rd_y = 8'd5;
    @(posedge clk); #1;
    chk("clr/pre_rd_d1", 128'(d1[1]), 128'(x2));
    chk("clr/pre_rd_d3", 128'(d1[3]), 128'(k3));
    chk("clr/ready_low", 128'(rdy1), 128'(0));
    i_clear = 1'b0;
    i_wr_x = 8'd20; i_wr_y = 8'd20;
    for (int q = 0; q < 4; q++) wr_data[q] = zz;
    i_rd_x = 8'd10; i_rd_y = 8'd10;
    cnt = 0;
    bad = 0;
    while (cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
      if (done1) break;
      if (v1 || rdy1 || rdr1) bad++;
    end
    chk("clr/cycles", 128'(cnt), 128'(4096));
    chk("clr/stalled", 128'(bad), 128'(0));
    chk("clr/ready_up", 128'(rdy1), 128'(1));
    chk("clr/rd_ready_up", 128'(rdr2), 128'(1));
    @(posedge clk); #1;
    i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    chk("clr/held_rd_v", 128'(v1), 128'(1));
    chk("clr/held_rd_d0", 128'(d1[0]), 128'(v));
    chk("clr/held_rd_d3", 128'(d1[3]), 128'(v));
    chk("clr/done_pulse", 128'(done1), 128'(0));
    @(posedge clk); #1;
    chk("clr/held_rd_l2", 128'(d2[1]), 128'(v));
    rd("clr_wr_kept", 8'd20, 8'd20, zz, zz, zz, zz, 4'hF);
    rd("clr_untouched", 8'd3, 8'd5, v, v, v, v, 4'hF);
    rd("clr_edge", 8'd127, 8'd10, v, z0, v, z0, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/tile_buffer_quad_unaligned.md
Name: tile_buffer_quad_unaligned

Overview:
- Next-generation on-chip tile colour/depth buffer for the tile-based rasteriser, parametrised in pixel width, tile size and read latency.
- Accepts 2x2 quad writes and reads at arbitrary (odd or even) x,y positions.
- Clips quads that straddle the right or bottom tile edge.
- Provides backpressured clear with write stalling.
- Sits between the raster backend (quad writes), the depth/blend stage (quad reads) and the tile writeback DMA.

Parameters:
POS_ADDRW, 8, width of x/y coordinates
TILE_WIDTH, 128, tile width in pixels; even, power of two
TILE_HEIGHT, 128, tile height in pixels; even, power of two
PIXEL_W, 72, bits per pixel (colour + depth); depth occupies bits [DEPTH_W-1:0]
DEPTH_W, 24, depth field width
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output pipeline register)
BANK_SIZE, (TILE_WIDTH/2)*(TILE_HEIGHT/2), entries per bank
INIT_CLEAR_VALUE, {colour 0, depth all-ones}, PIXEL_W value written by the post-reset clear

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
o_ready  out  1  high when in IDLE (not clearing)
i_wr_valid  in  1  quad write request
o_wr_ready  out  1  write accepted when valid&&ready; equals o_ready
i_wr_x, i_wr_y  in  POS_ADDRW  quad origin; any value
i_wr_data[4]  in  PIXEL_W  [0]=(x,y) [1]=(x+1,y) [2]=(x,y+1) [3]=(x+1,y+1)
i_wr_mask  in  4  per-pixel write enable, same indexing
i_rd_valid  in  1  quad read request
o_rd_ready  out  1  equals o_ready
i_rd_x, i_rd_y  in  POS_ADDRW  quad origin; any value
o_rd_data[4]  out  PIXEL_W  quad data in quad order
o_rd_inb  out  4  per-pixel in-bounds flag for returned data
o_rd_valid  out  1  read data valid
i_clear  in  1  start clear (sampled in IDLE only)
i_clear_value  in  PIXEL_W  fill value
o_clear_done  out  1  one-cycle pulse at end of clear

Behaviour:
- Storage: four banks indexed by (px&1)+2*(py&1), where px=x+dx, py=y+dy.
- Entry address = (py>>1)*(TILE_WIDTH/2)+(px>>1), computed at bank width.
- Odd origin: each quad pixel is routed to its bank through a crossbar selected by {y[0],x[0]}; bank addresses differ per bank (e.g. odd x: banks 0/2 use (x+1)>>1).
- Read data is un-swizzled back to quad order using the request's {y[0],x[0]}, delayed RD_LAT cycles.
- Out of bounds: px>=TILE_WIDTH or py>=TILE_HEIGHT, computed at POS_ADDRW+1 bits with no wrap.
  - OOB writes are suppressed regardless of mask.
  - OOB reads return 0 with o_rd_inb bit=0.
- Write: memory is updated at the clk edge where i_wr_valid&&o_wr_ready.
- Read: o_rd_valid asserts exactly RD_LAT cycles after an accepted read.
  - Back-to-back reads are fully pipelined, one quad per cycle.
  - o_rd_data holds its last value when o_rd_valid=0.
- Same-cycle read and write to the same entry: read returns the old data (read-first). Same-cycle read and write to different entries are independent.
- FSM states:
  - IDLE: on i_clear, latch i_clear_value, clear_addr=0, go to CLEAR. An i_clear in the same cycle as a write or read: the write and read are accepted first, then CLEAR starts.
  - CLEAR: write the latched value to clear_addr in all banks each cycle.
    - o_ready, o_wr_ready and o_rd_ready are 0; requests are stalled, not dropped; i_clear is ignored.
    - At clear_addr==BANK_SIZE-1, go to IDLE and pulse o_clear_done in the same cycle that o_ready rises.
  - Clear duration is exactly BANK_SIZE cycles.
- Reset: state=CLEAR, clear value=INIT_CLEAR_VALUE, clear_addr=0.
  - Output reset values: o_rd_valid=0, o_clear_done=0, o_ready=0, o_rd_data=0, o_rd_inb=0.
  - Read pipeline valid bits are flushed.
- Reset asserted mid-clear or mid-read restarts the clear; in-flight reads are discarded.

Test Plan:
- Reset, wait for clear -> o_clear_done pulses at cycle BANK_SIZE (4096) after rstn high; any read returns depth 24'hFFFFFF, colour 0, o_rd_inb=4'hF.
- Write quad at (3,5) with data A,B,C,D, mask F; read (3,5) -> o_rd_data=[A,B,C,D] after RD_LAT; read (2,4) -> [0] is cleared, [3]=A.
- Write at (127,10) mask F -> only (127,10) and (127,11) are stored; read (127,10) -> o_rd_inb=4'b0101, OOB words are 0; bank contents at x=0 are unchanged (no wrap).
- Mask 4'b1010 write over an existing quad -> only pixels 1 and 3 change.
- Same-cycle write X and read at the same (4,4) -> the read returns the old value; the next read returns X.
- Assert i_clear with value V while streaming reads and writes -> ready=0 for 4096 cycles, requests are held, nothing is lost after o_ready rises; reads return V for untouched pixels. Repeat with RD_LAT=2 -> latency is 2.
